// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one single-port memory channel.
// One transaction is in flight at a time; MEM wins unless it has starved IF for too long.
module mem_arbiter #(
    parameter int unsigned MAX_MEM_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        m_valid,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ready,
    input  logic        m_resp,
    input  logic [31:0] m_rdata,
    output logic        stall_if,
    output logic        stall_mem
);

    localparam int unsigned StreakW =
        (MAX_MEM_STREAK > 0) ? $clog2(MAX_MEM_STREAK + 1) : 1;
    localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_MEM_STREAK);

    typedef enum logic [1:0] {StIdle, StCmd, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic                owner_mem_q, owner_mem_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                grant_mem;

    // IF only overrides MEM once MEM has won MAX_MEM_STREAK times in a row with IF waiting.
    assign grant_mem = mem_req && !(if_req && (streak_q == StreakMax));

    always_comb begin
        state_d     = state_q;
        owner_mem_d = owner_mem_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        streak_d    = streak_q;
        case (state_q)
            StIdle: begin
                if (if_req || mem_req) begin
                    state_d     = StCmd;
                    owner_mem_d = grant_mem;
                    addr_d      = grant_mem ? mem_addr : if_addr;
                    we_d        = grant_mem && mem_we;
                    wdata_d     = grant_mem ? mem_wdata : 32'h0;
                    if (grant_mem && if_req) begin
                        streak_d = (streak_q == StreakMax) ? streak_q
                                                           : streak_q + StreakW'(1);
                    end else begin
                        streak_d = '0;
                    end
                end
            end
            StCmd: begin
                if (m_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (m_resp) begin
                    state_d = StDone;
                    // Write responses carry no data worth keeping.
                    if (owner_mem_q) begin
                        if (!we_q) begin
                            mem_rdata_d = m_rdata;
                        end
                    end else begin
                        if_rdata_d = m_rdata;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_mem_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_mem_q <= owner_mem_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            streak_q    <= streak_d;
        end
    end

    assign m_valid   = (state_q == StCmd);
    assign m_we      = we_q;
    assign m_addr    = addr_q;
    assign m_wdata   = wdata_q;
    assign if_done   = (state_q == StDone) && !owner_mem_q;
    assign mem_done  = (state_q == StDone) && owner_mem_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign stall_if  = if_req && !if_done;
    assign stall_mem = mem_req && !mem_done;

endmodule
